calc_result_sel: RTL and testbench
==================================

Name: calc_result_sel

Overview:
- Parametrised, registered successor to the calculator's combinational result multiplexer.
- Selects one of NUM_OPS operation results, waits for that unit's done, zero-extends or truncates the result to OUT_W and holds it under a valid/ready handshake.
- Flags bad selects, done timeouts and lossy truncation.
- Sits between the arithmetic/logic units and the display/UART output stage.

Parameters:
- NUM_OPS, 7, number of operation result channels (1..2**SEL_W).
- IN_W, 10, width of each result channel in op_data.
- OUT_W, 12, width of the output result.
- SEL_W, 3, width of the sel input.
- TIMEOUT, 16, cycles to wait for op_done before aborting (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_data  input  NUM_OPS*IN_W  packed results; channel k occupies bits [k*IN_W +: IN_W].
- op_done  input  NUM_OPS  per-channel result-ready level/pulse.
- sel  input  SEL_W  operation select, sampled only with start.
- start  input  1  request a result; accepted only in IDLE.
- out  output  OUT_W  registered selected result.
- out_valid  output  1  out holds a result not yet consumed.
- out_ready  input  1  consumer accepts out.
- busy  output  1  high in WAIT or HOLD.
- err_sel  output  1  sel was >= NUM_OPS; valid with out_valid.
- err_timeout  output  1  op_done never came; valid with out_valid.
- trunc  output  1  nonzero bits discarded by truncation; valid with out_valid.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE.
  - out=0, out_valid=0, busy=0, err_sel=0, err_timeout=0, trunc=0.
  - Timer=0, sel_q=0.
- FSM states IDLE, WAIT, HOLD. All outputs are registered.
- IDLE:
  - start=1 and sel<NUM_OPS: sel_q<=sel, timer<=0, go WAIT.
  - start=1 and sel>=NUM_OPS: out<=0, err_sel<=1, out_valid<=1, go HOLD.
  - Otherwise stay in IDLE.
- WAIT:
  - op_done is sampled from the cycle after start; done coincident with start is not captured.
  - op_done[sel_q]=1: out<=width-adapted channel sel_q, out_valid<=1, go HOLD. out_valid is high the cycle after done is seen.
  - Minimum start-to-out_valid latency is 2 cycles.
  - Else timer increments. At timer==TIMEOUT-1 with no done: out<=0, err_timeout<=1, out_valid<=1, go HOLD.
  - op_done bits other than sel_q are ignored.
- HOLD:
  - out and all flags stay stable.
  - out_ready=1: out_valid<=0 and all flags<=0 next cycle, go IDLE.
  - start is ignored in WAIT and HOLD, including start coincident with out_ready. Back-to-back requests need one IDLE cycle.
- out keeps its last value after the handshake until the next capture or error load.
- Width rule:
  - IN_W<=OUT_W: zero-extend, trunc=0.
  - IN_W>OUT_W: keep the low OUT_W bits; trunc=1 iff any discarded bit is 1.
- sel and op_data changes outside the capture cycle have no effect.

Test Plan:
- Reset then start, sel=2, channel2=10'h3A5, op_done[2] high 3 cycles later -> out_valid high 1 cycle after done, out=12'h3A5, busy=1, flags 0; out_ready=1 -> out_valid=0 and busy=0 next cycle, out stays 12'h3A5.
- start, sel=7 with NUM_OPS=7 -> next cycle out=0, out_valid=1, err_sel=1; held until out_ready, then err_sel=0.
- start, sel=1, op_done never asserted, TIMEOUT=16 -> out_valid rises after 16 WAIT cycles with out=0, err_timeout=1.
- op_done[4] pulses while sel_q=1, then op_done[1] with data 6'h2D -> only channel 1 captured, out=12'h02D. start pulsed during WAIT and HOLD is ignored.
- IN_W=16, OUT_W=12: data 16'h1ABC -> out=12'hABC, trunc=1; data 16'h0ABC -> trunc=0.
- rst_n pulsed low mid-WAIT and mid-HOLD -> all outputs 0 immediately without a clock edge. The next start after release behaves normally.

Source files
------------

// File: rtl/calc_result_sel.sv
// Registered result selector: picks one operation channel, waits for its done,
// width-adapts the result and holds it under a valid/ready handshake.
module calc_result_sel #(
    parameter int NUM_OPS = 7,
    parameter int IN_W    = 10,
    parameter int OUT_W   = 12,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_OPS*IN_W-1:0]  op_data,
    input  logic [NUM_OPS-1:0]       op_done,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     start,
    output logic [OUT_W-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     err_sel,
    output logic                     err_timeout,
    output logic                     trunc
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int EXT_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam logic [SEL_W:0] NUM_OPS_L = (SEL_W + 1)'(NUM_OPS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Returns {lossy, adapted}: zero-extend or keep the low OUT_W bits.
    function automatic logic [OUT_W:0] adapt_width(input logic [IN_W-1:0] din);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(din);
        adapt_width = {|(ext >> OUT_W), ext[OUT_W-1:0]};
    endfunction

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               err_sel_q, err_sel_d;
    logic               err_timeout_q, err_timeout_d;
    logic               trunc_q, trunc_d;

    logic [IN_W-1:0]    chan_data_s;
    logic               chan_done_s;
    logic               sel_ok_s;
    logic [OUT_W:0]     adapted_s;

    // Channel mux driven by the captured select.
    always_comb begin
        chan_data_s = '0;
        chan_done_s = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                chan_data_s = op_data[k*IN_W +: IN_W];
                chan_done_s = op_done[k];
            end else begin
                chan_data_s = chan_data_s;
                chan_done_s = chan_done_s;
            end
        end
        sel_ok_s  = ({1'b0, sel} < NUM_OPS_L);
        adapted_s = adapt_width(chan_data_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        timer_d       = timer_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        err_sel_d     = err_sel_q;
        err_timeout_d = err_timeout_q;
        trunc_d       = trunc_q;
        case (state_q)
            S_IDLE: begin
                if (start && sel_ok_s) begin
                    sel_d   = sel;
                    timer_d = '0;
                    state_d = S_WAIT;
                end else if (start) begin
                    out_d       = '0;
                    err_sel_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (chan_done_s) begin
                    out_d       = adapted_s[OUT_W-1:0];
                    trunc_d     = adapted_s[OUT_W];
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (timer_q == TMR_LAST) begin
                    out_d         = '0;
                    trunc_d       = 1'b0;
                    err_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    err_sel_d     = 1'b0;
                    err_timeout_d = 1'b0;
                    trunc_d       = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                out_valid_d   = 1'b0;
                err_sel_d     = 1'b0;
                err_timeout_d = 1'b0;
                trunc_d       = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            timer_q       <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            trunc_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            timer_q       <= timer_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            err_sel_q     <= err_sel_d;
            err_timeout_q <= err_timeout_d;
            trunc_q       <= trunc_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign err_sel     = err_sel_q;
    assign err_timeout = err_timeout_q;
    assign trunc       = trunc_q;

endmodule

// File: tb/tb_calc_result_sel.sv
// Scoreboard bench for calc_result_sel: a default instance (IN_W<OUT_W) and a
// truncating instance (IN_W=16, OUT_W=12).
module tb_calc_result_sel;

    typedef struct {
        logic [11:0] out;
        logic        es;
        logic        et;
        logic        tr;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [69:0] a_op_data;
    logic [6:0]  a_op_done;
    logic [2:0]  a_sel;
    logic        a_start;
    logic [11:0] a_out;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_busy;
    logic        a_err_sel;
    logic        a_err_to;
    logic        a_trunc;

    logic [31:0] b_op_data;
    logic [1:0]  b_op_done;
    logic [0:0]  b_sel;
    logic        b_start;
    logic [11:0] b_out;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_busy;
    logic        b_err_sel;
    logic        b_err_to;
    logic        b_trunc;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    calc_result_sel #(.NUM_OPS(7), .IN_W(10), .OUT_W(12), .SEL_W(3), .TIMEOUT(16)) u_a (
        .clk(clk), .rst_n(rst_n), .op_data(a_op_data), .op_done(a_op_done),
        .sel(a_sel), .start(a_start), .out(a_out), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy), .err_sel(a_err_sel),
        .err_timeout(a_err_to), .trunc(a_trunc)
    );

    calc_result_sel #(.NUM_OPS(2), .IN_W(16), .OUT_W(12), .SEL_W(1), .TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .op_data(b_op_data), .op_done(b_op_done),
        .sel(b_sel), .start(b_start), .out(b_out), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy), .err_sel(b_err_sel),
        .err_timeout(b_err_to), .trunc(b_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request on instance A; done_at<0 means op_done never comes.
    task automatic a_txn(input logic [2:0] s, input logic [9:0] data,
                         input int done_at, input bit noise);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        if (s < 3'd7) a_op_data[s*10 +: 10] = data;
        a_sel   = s;
        a_start = 1'b1;
        if (noise && s < 3'd7) a_op_done[s] = 1'b1;
        e.out = 12'h000; e.es = 1'b0; e.et = 1'b0; e.tr = 1'b0;
        if (s >= 3'd7) begin
            e.es = 1'b1; e.lat = 1;
        end else if (done_at < 0) begin
            e.et = 1'b1; e.lat = 17;
        end else begin
            e.out = {2'b00, data}; e.lat = done_at + 1;
        end
        qa.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            a_start   = 1'b0;
            a_op_done = '0;
            if (noise && n == 1) a_op_done[4] = 1'b1;
            if (noise && n == 2) begin a_start = 1'b1; a_sel = 3'd4; end
            if (a_out_valid) begin
                seen = 1'b1;
                lat  = n;
            end else if (n == done_at && s < 3'd7) begin
                a_op_done[s] = 1'b1;
            end
        end
        if (!seen) begin
            chk("a_valid_wait", 32'(seen), 32'd1);
            void'(qa.pop_front());
        end else begin
            e = qa.pop_front();
            chk("a_latency", lat, e.lat);
            chk("a_out", a_out, e.out);
            chk("a_err_sel", a_err_sel, e.es);
            chk("a_err_timeout", a_err_to, e.et);
            chk("a_trunc", a_trunc, e.tr);
            chk("a_busy_hold", a_busy, 1'b1);
            a_op_data = ~a_op_data;
            a_sel     = 3'd0;
            @(negedge clk);
            chk("a_out_stable", a_out, e.out);
            chk("a_valid_stable", a_out_valid, 1'b1);
            a_out_ready = 1'b1;
            if (noise) begin a_start = 1'b1; a_sel = 3'd0; end
            @(negedge clk);
            a_out_ready = 1'b0;
            a_start     = 1'b0;
            chk("a_valid_clr", a_out_valid, 1'b0);
            chk("a_busy_clr", a_busy, 1'b0);
            chk("a_flags_clr", {a_err_sel, a_err_to, a_trunc}, 3'b000);
            chk("a_out_kept", a_out, e.out);
            @(negedge clk);
            chk("a_idle_after", a_busy, 1'b0);
        end
    endtask

    // One request on the truncating instance B, done one cycle after start.
    task automatic b_txn(input logic [15:0] data);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        b_op_data[15:0] = data;
        b_sel   = 1'b0;
        b_start = 1'b1;
        e.out = data[11:0]; e.es = 1'b0; e.et = 1'b0; e.tr = |data[15:12]; e.lat = 2;
        qb.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 10 && !seen; n++) begin
            @(negedge clk);
            b_start   = 1'b0;
            b_op_done = '0;
            if (b_out_valid) begin
                seen = 1'b1;
                lat  = n;
            end else if (n == 1) begin
                b_op_done[0] = 1'b1;
            end
        end
        if (!seen) begin
            chk("b_valid_wait", 32'(seen), 32'd1);
            void'(qb.pop_front());
        end else begin
            e = qb.pop_front();
            chk("b_latency", lat, e.lat);
            chk("b_out", b_out, e.out);
            chk("b_trunc", b_trunc, e.tr);
            chk("b_errs", {b_err_sel, b_err_to}, {e.es, e.et});
            b_out_ready = 1'b1;
            @(negedge clk);
            b_out_ready = 1'b0;
            chk("b_valid_clr", b_out_valid, 1'b0);
            chk("b_trunc_clr", b_trunc, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_op_data = '0; a_op_done = '0; a_sel = '0; a_start = 1'b0; a_out_ready = 1'b0;
        b_op_data = '0; b_op_done = '0; b_sel = '0; b_start = 1'b0; b_out_ready = 1'b0;
        #12;
        chk("rst_a_outputs", {a_out, a_out_valid, a_busy, a_err_sel, a_err_to, a_trunc}, 17'd0);
        chk("rst_b_outputs", {b_out, b_out_valid, b_busy, b_err_sel, b_err_to, b_trunc}, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;

        a_txn(3'd2, 10'h3A5, 3, 1'b0);
        a_txn(3'd7, 10'h000, 0, 1'b0);
        a_txn(3'd1, 10'h111, -1, 1'b0);
        a_txn(3'd1, 10'h02D, 4, 1'b1);
        a_txn(3'd0, 10'h3FF, 1, 1'b0);
        a_txn(3'd6, 10'h200, 15, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a_txn(3'($urandom_range(0, 6)), 10'($urandom), int'($urandom_range(1, 6)), 1'b0);
        end

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        a_sel = 3'd1; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_wait_busy", a_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_outputs", {a_out_valid, a_busy, a_err_sel, a_err_to, a_trunc}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while a captured result is held.
        a_op_data[5*10 +: 10] = 10'h2C3;
        a_sel = 3'd5; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_op_done[5] = 1'b1;
        @(negedge clk);
        a_op_done = '0;
        chk("mid_hold_valid", a_out_valid, 1'b1);
        chk("mid_hold_out", a_out, 12'h2C3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hold_out", a_out, 12'h000);
        chk("rst_hold_flags", {a_out_valid, a_busy, a_err_sel, a_err_to, a_trunc}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_txn(3'd3, 10'h155, 2, 1'b0);

        b_txn(16'h1ABC);
        b_txn(16'h0ABC);
        b_txn(16'h8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
